// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: issues one imem request at a time for the current PC,
// buffers returned {pc, instr} pairs in a small FIFO for decode, and strobes the PC register.
module if_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [31:0]              pc_i,
    output logic                     pcwrite_o,
    input  logic                     flush_i,
    output logic                     imem_req_o,
    output logic [31:0]              imem_addr_o,
    input  logic                     imem_ack_i,
    input  logic [31:0]              imem_data_i,
    input  logic                     id_stall_i,
    output logic                     id_valid_o,
    output logic [31:0]              id_pc_o,
    output logic [31:0]              id_instr_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [1:0]               dbg_state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [31:0]   addr_q;
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic          issue, push, pop;

    // Handshake: imem_req_o rises on issue and stays high until the cycle imem_ack_i is seen;
    // a flush never retracts it, the late response is simply dropped in DROP.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (start_i && !flush_i && (count != FULL_CNT)) begin
                    issue     = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (imem_ack_i) begin
                    push      = !flush_i;
                    state_nxt = IDLE;
                end else if (flush_i) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (imem_ack_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign id_valid_o = (count != '0);
    assign pop        = id_valid_o && !id_stall_i && !flush_i;
    // Flush is gated by reset so the PC register is not written while held in reset
    assign pcwrite_o  = rst_i && (push || flush_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            addr_q <= '0;
        end else begin
            state <= state_nxt;
            if (issue) addr_q <= pc_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Issue reserves a slot, so a push never lands on a full FIFO
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wptr]    <= addr_q;
            instr_mem[wptr] <= imem_data_i;
        end
    end

    assign imem_req_o  = (state != IDLE);
    assign imem_addr_o = addr_q;
    assign id_pc_o     = id_valid_o ? pc_mem[rptr]    : '0;
    assign id_instr_o  = id_valid_o ? instr_mem[rptr] : '0;
    assign count_o     = count;
    assign dbg_state_o = state;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: a small request/FIFO model drives a
// scoreboard queue of expected {pc, instr} entries compared against the FIFO head.
module tb_if_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] pc_i;
    logic        pcwrite_o;
    logic        flush_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        id_stall_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_instr_o;
    logic [2:0]  count_o;
    logic [1:0]  dbg_state_o;

    int checks = 0;
    int errors = 0;

    // Scoreboard and request model
    logic [63:0] exp_q[$];
    logic        exp_req;
    logic        dropping;
    logic [31:0] exp_addr;

    if_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .pc_i        (pc_i),
        .pcwrite_o   (pcwrite_o),
        .flush_i     (flush_i),
        .imem_req_o  (imem_req_o),
        .imem_addr_o (imem_addr_o),
        .imem_ack_i  (imem_ack_i),
        .imem_data_i (imem_data_i),
        .id_stall_i  (id_stall_i),
        .id_valid_o  (id_valid_o),
        .id_pc_o     (id_pc_o),
        .id_instr_o  (id_instr_o),
        .count_o     (count_o),
        .dbg_state_o (dbg_state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_req  = 1'b0;
        dropping = 1'b0;
        exp_addr = '0;
    endtask

    // One clock cycle: drive inputs on the falling edge, check, then advance the model
    task automatic cyc(input logic s, input logic [31:0] pc, input logic ack,
                       input logic [31:0] data, input logic fl, input logic st);
        logic issue, accepted;
        int   size;
        @(negedge clk_i);
        start_i     = s;
        pc_i        = pc;
        imem_ack_i  = ack;
        imem_data_i = data;
        flush_i     = fl;
        id_stall_i  = st;
        #1;
        size = exp_q.size();
        check("req", 32'(imem_req_o), 32'(exp_req));
        if (exp_req) check("addr", imem_addr_o, exp_addr);
        check("count", 32'(count_o), 32'(size));
        check("valid", 32'(id_valid_o), 32'(size != 0));
        if (size == 0) begin
            check("empty_pc", id_pc_o, 32'h0);
            check("empty_instr", id_instr_o, 32'h0);
        end else begin
            check("head_pc", id_pc_o, exp_q[0][63:32]);
            check("head_instr", id_instr_o, exp_q[0][31:0]);
        end
        accepted = exp_req && ack && !dropping && !fl;
        check("pcwrite", 32'(pcwrite_o), 32'(accepted || fl));
        issue = !exp_req && s && !fl && (size < DEPTH);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (size != 0 && !st) void'(exp_q.pop_front());
            if (accepted) exp_q.push_back({exp_addr, data});
        end
        if (exp_req) begin
            if (ack) begin
                exp_req  = 1'b0;
                dropping = 1'b0;
            end else if (fl) begin
                dropping = 1'b1;
            end
        end else if (issue) begin
            exp_req  = 1'b1;
            exp_addr = pc;
        end
    endtask

    task automatic run_fetch(input logic [31:0] pc, input int lat, input logic st);
        cyc(1'b1, pc, 1'b0, 32'h0, 1'b0, st);
        for (int i = 0; i < lat; i++) cyc(1'b0, pc, 1'b0, 32'h0, 1'b0, st);
        cyc(1'b0, pc, 1'b1, pc + 32'hA0, 1'b0, st);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, 32'(imem_req_o), 32'h0);
        check({tag, "_addr"}, imem_addr_o, 32'h0);
        check({tag, "_count"}, 32'(count_o), 32'h0);
        check({tag, "_valid"}, 32'(id_valid_o), 32'h0);
        check({tag, "_pc"}, id_pc_o, 32'h0);
        check({tag, "_instr"}, id_instr_o, 32'h0);
        check({tag, "_pcwrite"}, 32'(pcwrite_o), 32'h0);
    endtask

    initial begin
        rst_i       = 1'b0;
        start_i     = 1'b0;
        pc_i        = '0;
        flush_i     = 1'b0;
        imem_ack_i  = 1'b0;
        imem_data_i = '0;
        id_stall_i  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_i);
        #1;
        check_reset_outputs("rst");
        @(negedge clk_i);
        rst_i = 1'b1;

        // Zero-wait fetch stream 0,4,8 with decode draining
        run_fetch(32'h0, 0, 1'b0);
        run_fetch(32'h4, 0, 1'b0);
        run_fetch(32'h8, 0, 1'b0);
        idle(2);

        // Fill under stall, full blocks issue, one pop then issue
        for (int i = 0; i < DEPTH; i++) run_fetch(32'h100 + 32'(4 * i), 0, 1'b1);
        cyc(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 32'h200, 1'b1, 32'h2A0, 1'b0, 1'b0);
        idle(6);

        // Flush during a 3-cycle wait: request held, data dropped, redirected PC fetched
        cyc(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 32'h40, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        run_fetch(32'h40, 0, 1'b0);
        idle(2);

        // Flush coincident with ack while two entries are queued
        run_fetch(32'h300, 0, 1'b1);
        run_fetch(32'h304, 0, 1'b1);
        cyc(1'b1, 32'h308, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 32'h500, 1'b1, 32'h3A8, 1'b1, 1'b1);
        idle(2);

        // Push and pop in the same cycle at count 2
        run_fetch(32'h400, 0, 1'b1);
        run_fetch(32'h404, 1, 1'b1);
        cyc(1'b1, 32'h408, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 32'h408, 1'b1, 32'h4A8, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        idle(4);

        // Random latencies and stalls
        for (int i = 0; i < 16; i++)
            run_fetch(32'h800 + 32'(4 * i), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        idle(6);

        // Reset while a request is outstanding; late ack afterwards is ignored
        run_fetch(32'h600, 0, 1'b1);
        cyc(1'b1, 32'h604, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 32'h604, 1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk_i);
        #2;
        rst_i   = 1'b0;
        flush_i = 1'b1;
        start_i = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk_i);
        flush_i = 1'b0;
        rst_i   = 1'b1;
        model_reset();
        cyc(1'b0, 32'h604, 1'b1, 32'h6A4, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        run_fetch(32'h700, 0, 1'b0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Instruction-fetch stage between the PC register and the IF/ID boundary. Issues one instruction-memory request at a time for the current PC, buffers returned {pc, instr} pairs in a small FIFO, presents them to decode, and produces the PC-advance strobe that drives the PC register's write-enable. On a taken branch/jump (flush) it empties the FIFO, discards any in-flight response, and strobes the PC so it loads the redirect target.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  CPU run enable; 0 blocks new requests
- pc_i  in  32  current PC (PC register output)
- pcwrite_o  out  1  PC write-enable strobe to PC register
- flush_i  in  1  branch/jump taken this cycle; redirect target already on PC input mux
- imem_req_o  out  1  memory request valid
- imem_addr_o  out  32  request address
- imem_ack_i  in  1  memory response valid; meaningful only while imem_req_o=1
- imem_data_i  in  32  instruction word, valid with imem_ack_i
- id_stall_i  in  1  decode stall (hazard unit)
- id_valid_o  out  1  head entry valid
- id_pc_o  out  32  head entry PC
- id_instr_o  out  32  head entry instruction
- count_o  out  log2(DEPTH)+1  FIFO occupancy

## Operation
- FSM states: IDLE, REQ, DROP. imem_req_o = (state≠IDLE), registered.
- IDLE→REQ when start_i=1, flush_i=0, count_o<DEPTH; imem_addr_o ← pc_i on that edge, held stable until ack.
- REQ, imem_ack_i=1, flush_i=0: push {imem_addr_o, imem_data_i}; pcwrite_o=1 (combinational, same cycle); →IDLE.
- REQ, imem_ack_i=1, flush_i=1: response discarded, no push; →IDLE.
- REQ, imem_ack_i=0, flush_i=1: →DROP. Request is never retracted; imem_req_o stays 1.
- DROP: wait for imem_ack_i; discard data, pcwrite_o=0; →IDLE. Further flush_i in DROP: stay DROP.
- pcwrite_o = (REQ & imem_ack_i & ~flush_i) | flush_i.
- Slot reservation: issue only if count_o<DEPTH; count_o only falls while outstanding, so a push never overflows.
- id_valid_o = (count_o≠0); id_pc_o/id_instr_o = head entry (0 when empty).
- Pop when id_valid_o & ~id_stall_i & ~flush_i.
- Simultaneous push and pop: count_o unchanged, both pointers advance.
- flush_i clears FIFO on the edge (count_o←0, pointers←0), overriding push/pop.
- start_i=0 while REQ: outstanding request completes normally; no new issue.
- imem_ack_i in IDLE ignored.

## Timing
- Reset (async, rst_i=0): state IDLE, imem_req_o=0, imem_addr_o=0, count_o=0, id_valid_o=0, id_pc_o=0, id_instr_o=0, pcwrite_o=0 (flush_i gated off during reset), pointers 0.
- Reset mid-request: outstanding request abandoned; stale ack after release ignored (state IDLE).
- Fetch cadence: issue edge E0 → imem_req_o=1 from cycle 1; ack in cycle k → push and PC update at end of cycle k; IDLE in cycle k+1 with new pc_i; next issue at end of k+1. Zero-wait memory (ack in first REQ cycle): one instruction per 2 cycles.
- Push at end of ack cycle → id_valid_o=1 next cycle (1-cycle latency from ack to decode visibility).
- Flush: FIFO empty and id_valid_o=0 the cycle after flush_i; PC holds target the same cycle.
- Full: count_o=DEPTH holds FSM in IDLE until a pop; issue can occur on the edge of the pop only if count_o<DEPTH before that edge (no look-ahead).

## Test plan
- Reset then start_i=1, pc sequence 0,4,8, zero-wait ack with data 0xA0,0xA4,0xA8, id_stall_i=0 → imem_addr_o 0,4,8; id_instr_o 0xA0,0xA4,0xA8 with id_pc_o 0,4,8; pcwrite_o one pulse per ack.
- id_stall_i=1 held, DEPTH=4 → after 4 acks count_o=4, imem_req_o stays 0; release stall one cycle → one pop, count_o=3, next request issues following cycle.
- Request to 0x10 with 3-cycle ack latency, flush_i pulsed in cycle 1 of wait → imem_req_o held until ack, data discarded, pcwrite_o=1 only in flush cycle, FIFO empty, next request uses redirected pc_i (e.g. 0x40).
- flush_i coincident with ack and with count_o=2 → no push, count_o=0 next cycle, pcwrite_o=1 exactly once.
- count_o=2, push and pop same cycle → count_o stays 2, head advances to next entry in order.
- rst_i low while imem_req_o=1, ack arrives after release → all outputs reset values, ack ignored, no push, no pcwrite_o.
